// File: rtl/sru_bitstream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sru_bitstream_pkg
// Description : Shared definitions for the SRU configuration bitstream link
//               (FSM encodings, bit-order names, width derivation helpers).
// Revision    : 1.0 - initial release
// ============================================================================
package sru_bitstream_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam bit c_BIT_ORDER_LSB_FIRST = 1'b0;
  localparam bit c_BIT_ORDER_MSB_FIRST = 1'b1;

  localparam int c_DEFAULT_NUM_NETS     = 16;
  localparam int c_DEFAULT_BITS_PER_NET = 4;

  // Both link ends derive the word width from the same net geometry.
  function automatic int cfgSizeFor(input int numNets, input int bitsPerNet);
    return numNets * bitsPerNet;
  endfunction

  // Width needed to hold 0..maxVal, never narrower than one bit.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sru_bitstream_serializer.sv
`default_nettype none
// ============================================================================
// Module      : sru_bitstream_serializer
// Description : Shifts a parallel SRU configuration word out on a serial line
//               with a valid strobe; supports pause, abort and a guard gap.
// Revision    : 1.0 - initial release
// ============================================================================
module sru_bitstream_serializer
  import sru_bitstream_pkg::*;
#(
  parameter int CFG_SIZE   = cfgSizeFor(c_DEFAULT_NUM_NETS, c_DEFAULT_BITS_PER_NET),
  parameter bit MSB_FIRST  = c_BIT_ORDER_LSB_FIRST,
  parameter int GAP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CFG_SIZE-1:0] CfgIn,
  input  logic                Start,
  input  logic                Pause,
  input  logic                Abort,
  output logic                SerialOut,
  output logic                StreamValid,
  output logic                Busy,
  output logic                Done
);

  localparam int c_BIT_CNT_W = cntWidth(CFG_SIZE - 1);
  localparam int c_GAP_CNT_W = cntWidth(GAP_CYCLES);
  localparam logic [c_BIT_CNT_W-1:0] c_BIT_CNT_LOAD = c_BIT_CNT_W'(CFG_SIZE - 1);
  localparam logic [c_BIT_CNT_W-1:0] c_BIT_CNT_ONE  = c_BIT_CNT_W'(1);
  localparam logic [c_GAP_CNT_W-1:0] c_GAP_CNT_LOAD = c_GAP_CNT_W'(GAP_CYCLES);
  localparam logic [c_GAP_CNT_W-1:0] c_GAP_CNT_ONE  = c_GAP_CNT_W'(1);
  localparam bit c_HAS_GAP = (GAP_CYCLES != 0);

  logic [1:0]             r_state;
  logic [1:0]             w_stateNext;
  logic [CFG_SIZE-1:0]    r_shift;
  logic [CFG_SIZE-1:0]    w_shiftNext;
  logic [c_BIT_CNT_W-1:0] r_bitCnt;
  logic [c_BIT_CNT_W-1:0] w_bitCntNext;
  logic [c_GAP_CNT_W-1:0] r_gapCnt;
  logic [c_GAP_CNT_W-1:0] w_gapCntNext;
  logic                   r_serial;
  logic                   w_serialNext;
  logic                   r_valid;
  logic                   w_validNext;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_doneNext;

  logic                   w_firstBit;
  logic                   w_nextBit;
  logic [CFG_SIZE-1:0]    w_shiftLoad;
  logic [CFG_SIZE-1:0]    w_shiftStep;

  // The shift register holds only the bits not yet driven onto the line.
  generate
    if (MSB_FIRST == c_BIT_ORDER_MSB_FIRST) begin : g_msbFirst
      assign w_firstBit  = CfgIn[CFG_SIZE-1];
      assign w_shiftLoad = {CfgIn[CFG_SIZE-2:0], 1'b0};
      assign w_nextBit   = r_shift[CFG_SIZE-1];
      assign w_shiftStep = {r_shift[CFG_SIZE-2:0], 1'b0};
    end else begin : g_lsbFirst
      assign w_firstBit  = CfgIn[0];
      assign w_shiftLoad = {1'b0, CfgIn[CFG_SIZE-1:1]};
      assign w_nextBit   = r_shift[0];
      assign w_shiftStep = {1'b0, r_shift[CFG_SIZE-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_bitCnt <= '0;
      r_gapCnt <= '0;
      r_serial <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_shift  <= w_shiftNext;
      r_bitCnt <= w_bitCntNext;
      r_gapCnt <= w_gapCntNext;
      r_serial <= w_serialNext;
      r_valid  <= w_validNext;
      r_busy   <= (w_stateNext != ST_IDLE);
      r_done   <= w_doneNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    if (Abort) begin
      w_stateNext = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (Start) w_stateNext = ST_SHIFT;
        ST_SHIFT: if (r_bitCnt == '0) w_stateNext = c_HAS_GAP ? ST_GAP : ST_IDLE;
        ST_GAP:   if (r_gapCnt <= c_GAP_CNT_ONE) w_stateNext = ST_IDLE;
        default:  w_stateNext = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_shiftNext  = r_shift;
    w_bitCntNext = r_bitCnt;
    w_gapCntNext = r_gapCnt;
    w_serialNext = r_serial;
    w_validNext  = 1'b0;
    w_doneNext   = 1'b0;
    if (Abort) begin
      w_bitCntNext = '0;
      w_gapCntNext = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            w_serialNext = w_firstBit;
            w_validNext  = 1'b1;
            w_shiftNext  = w_shiftLoad;
            w_bitCntNext = c_BIT_CNT_LOAD;
          end
        end
        ST_SHIFT: begin
          // A zero count means the final bit is already on the line.
          if (r_bitCnt == '0) begin
            if (c_HAS_GAP) w_gapCntNext = c_GAP_CNT_LOAD;
            else           w_doneNext   = 1'b1;
          end else if (!Pause) begin
            w_serialNext = w_nextBit;
            w_validNext  = 1'b1;
            w_shiftNext  = w_shiftStep;
            w_bitCntNext = r_bitCnt - c_BIT_CNT_ONE;
          end
        end
        ST_GAP: begin
          if (r_gapCnt <= c_GAP_CNT_ONE) begin
            w_gapCntNext = '0;
            w_doneNext   = 1'b1;
          end else begin
            w_gapCntNext = r_gapCnt - c_GAP_CNT_ONE;
          end
        end
        default: begin
          w_bitCntNext = '0;
          w_gapCntNext = '0;
        end
      endcase
    end
  end

  assign SerialOut   = r_serial;
  assign StreamValid = r_valid;
  assign Busy        = r_busy;
  assign Done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sru_bitstream_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sru_bitstream_serializer
// Description : Scoreboard bench for sru_bitstream_serializer (LSB-first with
//               guard gap, and MSB-first with no gap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sru_bitstream_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] aCfg = '0;
  logic [W-1:0] bCfg = '0;
  logic         aStart = 1'b0, aPause = 1'b0, aAbort = 1'b0;
  logic         bStart = 1'b0, bPause = 1'b0, bAbort = 1'b0;
  logic         aSerial, aValid, aBusy, aDone;
  logic         bSerial, bValid, bBusy, bDone;

  int           nChecks = 0;
  int           nErrors = 0;
  logic         qA[$];
  logic         qB[$];
  logic [W-1:0] wA[$];
  logic [W-1:0] wB[$];
  logic [W-1:0] aRx = '0;
  logic [W-1:0] bRx = '0;
  int           aCnt = 0;
  int           bCnt = 0;

  sru_bitstream_serializer #(.CFG_SIZE(W), .MSB_FIRST(1'b0), .GAP_CYCLES(2)) uLsb (
    .clk(clk), .rst(rst), .CfgIn(aCfg), .Start(aStart), .Pause(aPause), .Abort(aAbort),
    .SerialOut(aSerial), .StreamValid(aValid), .Busy(aBusy), .Done(aDone)
  );

  sru_bitstream_serializer #(.CFG_SIZE(W), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) uMsb (
    .clk(clk), .rst(rst), .CfgIn(bCfg), .Start(bStart), .Pause(bPause), .Abort(bAbort),
    .SerialOut(bSerial), .StreamValid(bValid), .Busy(bBusy), .Done(bDone)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushA(input logic [W-1:0] word);
    for (int i = 0; i < W; i++) qA.push_back(word[i]);
    wA.push_back(word);
  endtask

  task automatic pushB(input logic [W-1:0] word);
    for (int i = W - 1; i >= 0; i--) qB.push_back(word[i]);
    wB.push_back(word);
  endtask

  // Receiver model: pops expected bits, reassembles the word, counts valids.
  always @(negedge clk) begin
    if (rst) begin
      aCnt = 0;
    end else begin
      if (aValid) begin
        checkVal("A bit queue nonempty", (qA.size() != 0), 1);
        if (qA.size() != 0) checkVal("A serial bit", aSerial, qA.pop_front());
        aRx = {aSerial, aRx[W-1:1]};
        aCnt++;
      end
      if (aDone) begin
        checkVal("A valid count", aCnt, W);
        checkVal("A word queue nonempty", (wA.size() != 0), 1);
        if (wA.size() != 0) checkVal("A rx word", aRx, wA.pop_front());
        aCnt = 0;
      end else if (!aBusy) begin
        aCnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      bCnt = 0;
    end else begin
      if (bValid) begin
        checkVal("B bit queue nonempty", (qB.size() != 0), 1);
        if (qB.size() != 0) checkVal("B serial bit", bSerial, qB.pop_front());
        bRx = {bRx[W-2:0], bSerial};
        bCnt++;
      end
      if (bDone) begin
        checkVal("B valid count", bCnt, W);
        checkVal("B word queue nonempty", (wB.size() != 0), 1);
        if (wB.size() != 0) checkVal("B rx word", bRx, wB.pop_front());
        bCnt = 0;
      end else if (!bBusy) begin
        bCnt = 0;
      end
    end
  end

  initial begin
    tick();
    tick();
    checkVal("reset A outs", {aSerial, aValid, aBusy, aDone}, 0);
    checkVal("reset B outs", {bSerial, bValid, bBusy, bDone}, 0);
    rst = 1'b0;

    // Plain A5 transfer, LSB first, 2-cycle gap
    aCfg = 8'hA5; aStart = 1'b1; pushA(8'hA5);
    for (int c = 1; c <= 12; c++) begin
      tick(); aStart = 1'b0;
      checkVal($sformatf("t1 valid c%0d", c), aValid, (c <= 8));
      checkVal($sformatf("t1 busy c%0d", c), aBusy, (c <= 10));
      checkVal($sformatf("t1 done c%0d", c), aDone, (c == 11));
    end

    // Pause high in cycles 3-4
    aCfg = 8'hA5; aStart = 1'b1; pushA(8'hA5);
    for (int c = 1; c <= 14; c++) begin
      tick(); aStart = 1'b0; aPause = (c == 3 || c == 4);
      checkVal($sformatf("t3 valid c%0d", c), aValid, ((c <= 3) || (c >= 6 && c <= 10)));
      checkVal($sformatf("t3 done c%0d", c), aDone, (c == 13));
      checkVal($sformatf("t3 busy c%0d", c), aBusy, (c <= 12));
      if (c == 4 || c == 5) checkVal($sformatf("t3 held serial c%0d", c), aSerial, 1);
    end
    aPause = 1'b0;

    // Abort sampled in cycle 4
    aCfg = 8'hA5; aStart = 1'b1; pushA(8'hA5);
    for (int c = 1; c <= 12; c++) begin
      tick(); aStart = 1'b0; aAbort = (c == 4);
      if (c >= 5) begin
        checkVal($sformatf("t4 valid c%0d", c), aValid, 0);
        checkVal($sformatf("t4 busy c%0d", c), aBusy, 0);
      end
      checkVal($sformatf("t4 done c%0d", c), aDone, 0);
    end
    checkVal("t4 unsent bits", qA.size(), 4);
    qA.delete(); wA.delete();

    // Start together with Abort in IDLE
    aStart = 1'b1; aAbort = 1'b1;
    tick(); aStart = 1'b0; aAbort = 1'b0;
    checkVal("t4 start+abort busy", aBusy, 0);
    checkVal("t4 start+abort valid", aValid, 0);
    tick();
    checkVal("t4 start+abort busy later", aBusy, 0);

    // Back-to-back with Start held high; CfgIn changes while busy
    aCfg = 8'hFF; aStart = 1'b1; pushA(8'hFF); pushA(8'h00);
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 1) aCfg = 8'h00;
      if (c == 12) aStart = 1'b0;
      checkVal($sformatf("t5 valid c%0d", c), aValid, ((c <= 8) || (c >= 12 && c <= 19)));
      checkVal($sformatf("t5 done c%0d", c), aDone, (c == 11 || c == 22));
      checkVal($sformatf("t5 busy c%0d", c), aBusy, ((c <= 10) || (c >= 12 && c <= 21)));
      if (c == 12) checkVal("t5 second first bit", aSerial, 0);
    end

    // Asynchronous reset between edges mid-SHIFT
    aCfg = 8'hA5; aStart = 1'b1; pushA(8'hA5);
    tick(); aStart = 1'b0;
    tick();
    tick();
    #3 rst = 1'b1;
    #1;
    checkVal("t6 async reset outs", {aSerial, aValid, aBusy, aDone}, 0);
    #2;
    qA.delete(); wA.delete();
    tick(); rst = 1'b0;
    aCfg = 8'h3C; aStart = 1'b1; pushA(8'h3C);
    for (int c = 1; c <= 12; c++) begin
      tick(); aStart = 1'b0;
      checkVal($sformatf("t6 valid c%0d", c), aValid, (c <= 8));
      checkVal($sformatf("t6 done c%0d", c), aDone, (c == 11));
    end

    // MSB first, zero gap
    bCfg = 8'hA5; bStart = 1'b1; pushB(8'hA5);
    for (int c = 1; c <= 10; c++) begin
      tick(); bStart = 1'b0;
      checkVal($sformatf("t2 valid c%0d", c), bValid, (c <= 8));
      checkVal($sformatf("t2 done c%0d", c), bDone, (c == 9));
      checkVal($sformatf("t2 busy c%0d", c), bBusy, (c <= 8));
    end
    bCfg = 8'h01; bStart = 1'b1; pushB(8'h01);
    for (int c = 1; c <= 10; c++) begin
      tick(); bStart = 1'b0;
      checkVal($sformatf("t2b valid c%0d", c), bValid, (c <= 8));
      checkVal($sformatf("t2b done c%0d", c), bDone, (c == 9));
      if (c == 7) checkVal("t2b bit6", bSerial, 0);
      if (c == 8) checkVal("t2b bit7", bSerial, 1);
    end

    tick();
    checkVal("A queue drained", qA.size() + wA.size(), 0);
    checkVal("B queue drained", qB.size() + wB.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sru_bitstream_serializer.md
Name: sru_bitstream_serializer

Overview:
Transmit end of the SRU configuration bitstream link. It takes a parallel (already encrypted) CFG_SIZE-bit configuration word and shifts it out on a single serial line with a qualifying valid strobe. It drives the SRU's bitstreamSerialIn/bitstreamValid pins from an on-chip config master, such as a patch loader or debug TAP bridge. It supports pause (back-pressure), abort, and a programmable idle guard gap before completion.

Parameters:
CFG_SIZE, 64, width of the configuration word (must equal the receiving SRU's net cfg width); >= 2
MSB_FIRST, 0, 0 = shift CfgIn[0] first; 1 = shift CfgIn[CFG_SIZE-1] first
GAP_CYCLES, 2, guard cycles with StreamValid low after the last bit, before Done; 0 allowed

Ports:
clk  in  1  single clock (cfg clock domain of the link)
rst  in  1  asynchronous reset, active-high
CfgIn  in  CFG_SIZE  parallel word; sampled only on an accepted Start
Start  in  1  request to transmit; accepted only when Busy=0
Pause  in  1  hold stream; no bit emitted in the following cycle
Abort  in  1  terminate the transfer; return to IDLE, no Done
SerialOut  out  1  serial data bit (to bitstreamSerialIn)
StreamValid  out  1  SerialOut qualifier (to bitstreamValid)
Busy  out  1  transfer in progress
Done  out  1  one-cycle pulse on normal completion

Behaviour:
- All outputs are registered. Reset (async, any time, including mid-stream): SerialOut=0, StreamValid=0, Busy=0, Done=0, shift reg=0, counters=0, state=IDLE.
- States: IDLE, SHIFT, GAP. Encodings are 2-bit localparams. Busy = (state != IDLE).
- Cycle numbering: Start sampled high in cycle 0.
- IDLE + Start (Abort low):
  - Capture edge drives the first bit: SerialOut=CfgIn[0] (or [CFG_SIZE-1] if MSB_FIRST), StreamValid=1.
  - Shift reg loads the remaining CFG_SIZE-1 bits; bit counter = CFG_SIZE-1; next state SHIFT.
  - Pause is ignored at the capture edge.
- SHIFT:
  - Pause=0: emit next bit, decrement counter. Bit k is visible in cycle 1+k when no pauses occur.
  - Pause=1: StreamValid=0 next cycle, SerialOut holds its last value, counter and shift reg hold. Each Pause-high cycle inserts exactly one invalid cycle.
  - When counter=0 and the last bit has been emitted: next cycle StreamValid=0. Go to GAP with gap counter=GAP_CYCLES, or straight to IDLE with Done if GAP_CYCLES=0.
- GAP: StreamValid=0 and Pause is ignored. Decrement to 0, then transition to IDLE with Done=1 for that single cycle.
- Unpaused totals: last bit in cycle CFG_SIZE; Done and Busy=0 in cycle CFG_SIZE+GAP_CYCLES+1.
- Start in the Done cycle (Busy=0) is accepted, giving back-to-back streams with no extra gap.
- Start while Busy=1 is ignored; there is no queueing.
- Abort (any state) sampled in cycle n: in cycle n+1 state=IDLE, StreamValid=0, Busy=0, Done=0.
- Abort with Start in IDLE: Abort wins, Start is dropped.
- Abort with Pause: Abort wins.
- Counter widths: bit counter $clog2(CFG_SIZE); gap counter max(1,$clog2(GAP_CYCLES+1)). No wrap-around: counters never decrement below 0.
- The receiver sees exactly CFG_SIZE StreamValid-high cycles per non-aborted transfer.

Decomposition:
- Shared package sru_bitstream_pkg holds:
  - state encodings (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_GAP=2'd2);
  - the bit-order constant names;
  - a common CFG_SIZE derivation function, so serializer and deserializer agree on width.
- No sub-module. Shift register, two counters and the FSM stay in one module (about 150-200 lines).

Test Plan:
1. CFG_SIZE=8, GAP_CYCLES=2, MSB_FIRST=0, CfgIn=8'hA5, Start in cycle 0 -> SerialOut 1,0,1,0,0,1,0,1 with StreamValid=1 in cycles 1-8; StreamValid=0 in cycles 9-10; Done=1 and Busy=0 in cycle 11 only.
2. Same config, MSB_FIRST=1, CfgIn=8'hA5 -> bits 1,0,1,0,0,1,0,1 (palindrome check), then repeat with CfgIn=8'h01 -> 0,0,0,0,0,0,0,1. Loopback into the deserializer yields CfgIn exactly.
3. Pause high in cycles 3-4 during 8'hA5 -> StreamValid=0 in cycles 4-5 with SerialOut held; remaining bits in cycles 6-10; Done in cycle 13; exactly 8 valid cycles.
4. Abort in cycle 4 -> cycle 5: StreamValid=0, Busy=0, Done never asserted. Start+Abort together in IDLE -> Busy stays 0.
5. Back-to-back: Start held high continuously with CfgIn=8'hFF then 8'h00 -> second stream's first bit in cycle 12 (the Done cycle is the accept cycle); Start during Busy is ignored.
6. rst asserted asynchronously mid-SHIFT (between edges) -> outputs go to 0 immediately. After release, a Start with 8'h3C transmits cleanly from bit 0.
